// File: rtl/cmp_pkg.sv
// =============================================================================
//  Module      : cmp_pkg
//  Description : Shared types and constants for the sequential comparator.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_t;

    // Result encoding, packed as {gt, eq, lt}
    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

    function automatic int cmp_nslice(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_slice.sv
// =============================================================================
//  Module      : cmp_slice
//  Description : Combinational unsigned magnitude compare of one operand slice.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module cmp_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    output logic             gt_o,
    output logic             lt_o
);

    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);

endmodule

`default_nettype wire

// File: rtl/seq_comparator.sv
// =============================================================================
//  Module      : seq_comparator
//  Description : Multi-cycle signed/unsigned magnitude comparator, MSB slice
//                first, with valid/ready request and result handshakes.
//                Optional macro SEQ_CMP_EARLY_EXIT_EN ends the scan on the
//                first differing slice.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module seq_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             busy
);

    localparam int NSLICE = cmp_nslice(WIDTH, SLICE);
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

    if (WIDTH % SLICE != 0) begin : g_width_check
        $error("seq_comparator: WIDTH must be a multiple of SLICE");
    end

    cmp_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [1:0]       dec_q, dec_d;   // {gt, lt} of the most significant differing slice so far
    logic [2:0]       res_q, res_d;

    logic [SLICE-1:0] w_slice_a;
    logic [SLICE-1:0] w_slice_b;
    logic             w_sgt;
    logic             w_slt;
    logic             w_gt;
    logic             w_lt;
    logic             w_exit;

    assign w_slice_a = a_q[idx_q*SLICE +: SLICE];
    assign w_slice_b = b_q[idx_q*SLICE +: SLICE];

    cmp_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_i  (w_slice_a),
        .b_i  (w_slice_b),
        .gt_o (w_sgt),
        .lt_o (w_slt)
    );

    // Once a higher slice has decided, lower slices must not override it
    assign w_gt = (dec_q == 2'b00) ? w_sgt : dec_q[1];
    assign w_lt = (dec_q == 2'b00) ? w_slt : dec_q[0];

`ifdef SEQ_CMP_EARLY_EXIT_EN
    assign w_exit = w_sgt | w_slt;
`else
    assign w_exit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    // Flipping the sign bit maps two's-complement order onto unsigned order
                    a_d              = a;
                    b_d              = b;
                    a_d[WIDTH-1]     = a[WIDTH-1] ^ signed_mode;
                    b_d[WIDTH-1]     = b[WIDTH-1] ^ signed_mode;
                    idx_d            = IDX_LAST;
                    dec_d            = 2'b00;
                    state_d          = ST_SCAN;
                end
            end
            ST_SCAN: begin
                dec_d = {w_gt, w_lt};
                if (w_exit || (idx_q == '0)) begin
                    res_d   = w_gt ? CMP_GT : (w_lt ? CMP_LT : CMP_EQ);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    res_d   = CMP_NONE;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                res_d   = CMP_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            dec_q   <= 2'b00;
            res_q   <= CMP_NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            res_q   <= res_d;
        end
    end

    assign start_ready  = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign {gt, eq, lt} = res_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_comparator.sv
// =============================================================================
//  Module      : tb_seq_comparator
//  Description : Directed self-checking bench for seq_comparator (32/8).
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_seq_comparator;

    localparam logic [2:0] R_GT   = 3'b100;
    localparam logic [2:0] R_EQ   = 3'b010;
    localparam logic [2:0] R_LT   = 3'b001;
    localparam logic [2:0] R_NONE = 3'b000;

`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        signed_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        gt, eq, lt, busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_comparator #(
        .WIDTH (32),
        .SLICE (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .gt          (gt),
        .eq          (eq),
        .lt          (lt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected cycles from handshake to out_valid; m = first differing slice from top
    function automatic int lat(input int m);
        return EARLY ? (m + 2) : 5;
    endfunction

    task automatic start_req(input logic [31:0] va, input logic [31:0] vb, input logic sm,
                             input string tag);
        @(negedge clk);
        a = va; b = vb; signed_mode = sm; start_valid = 1'b1;
        check({tag, "_start_ready"}, {31'd0, start_ready}, 32'd1);
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    task automatic wait_result(input logic [2:0] exp_res, input int exp_lat, input string tag);
        int j;
        j = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                j = i;
                break;
            end
        end
        check({tag, "_latency"}, j, exp_lat);
        check({tag, "_result"}, {29'd0, gt, eq, lt}, {29'd0, exp_res});
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle_res"}, {29'd0, gt, eq, lt}, {29'd0, R_NONE});
        check({tag, "_idle_ready"}, {31'd0, start_ready}, 32'd1);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run(input logic [31:0] va, input logic [31:0] vb, input logic sm,
                       input logic [2:0] exp_res, input int exp_lat, input string tag);
        start_req(va, vb, sm, tag);
        wait_result(exp_res, exp_lat, tag);
        retire(tag);
    endtask

    initial begin
        int seen;
        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_res", {29'd0, gt, eq, lt}, {29'd0, R_NONE});
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, start_ready}, 32'd1);

        // Directed compares
        run(32'h8000_0000, 32'h0000_0001, 1'b0, R_GT, lat(0), "t1_unsigned_msb");
        run(32'h8000_0000, 32'h0000_0001, 1'b1, R_LT, lat(0), "t2_signed_msb");
        run(32'h1234_5678, 32'h1234_5678, 1'b0, R_EQ, 5, "t3_eq_unsigned");
        run(32'h1234_5678, 32'h1234_5678, 1'b1, R_EQ, 5, "t3_eq_signed");
        run(32'h0000_0002, 32'h0000_0003, 1'b0, R_LT, 5, "t4_low_slice");
        run(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, R_LT, lat(0), "t4_neg1_vs_0");
        run(32'h1234_0000, 32'h1233_FFFF, 1'b0, R_GT, lat(1), "tx_slice2");
        run(32'h0000_01FF, 32'h0000_0200, 1'b0, R_LT, lat(2), "tx_no_override");
        run(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, R_GT, lat(0), "tx_max_vs_min");

        // Back-pressure with start_valid held high throughout
        @(negedge clk);
        a = 32'h8000_0000; b = 32'h0000_0001; signed_mode = 1'b0; start_valid = 1'b1;
        @(posedge clk);
        #1 a = 32'h0000_0000; b = 32'hFFFF_FFFF;
        wait_result(R_GT, lat(0), "t5_first");
        check("t5_ready_low", {31'd0, start_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t5_hold_res", {29'd0, gt, eq, lt}, {29'd0, R_GT});
            check("t5_hold_ready", {31'd0, start_ready}, 32'd0);
        end
        a = 32'h0000_0002; b = 32'h0000_0003; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("t5_idle_ready", {31'd0, start_ready}, 32'd1);
        check("t5_idle_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1 start_valid = 1'b0;
        wait_result(R_LT, 5, "t5_second");
        retire("t5_second");

        // Reset during the second SCAN cycle
        start_req(32'h0000_0002, 32'h0000_0003, 1'b0, "t6_abort");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        check("t6_res", {29'd0, gt, eq, lt}, {29'd0, R_NONE});
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_ready", {31'd0, start_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        check("t6_no_result", seen, 0);
        run(32'h0000_0010, 32'h0000_0010, 1'b1, R_EQ, 5, "t6_fresh");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
